secuencia_bcd_scan: RTL and testbench
=====================================

SECUENCIA_BCD_SCAN -- requirements
Module: secuencia_bcd_scan

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, SHALL set the clock cycles per count step; legal range is at least 1.
REQ-002 Parameter SCAN_DIV, default 50_000, SHALL set the clock cycles per display slot; legal range is at least 1.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the count enable; when 0, the prescaler and the count hold.
REQ-006 dir  input  1  SHALL select the count direction: 0 counts up, 1 counts down.
REQ-007 clr  input  1  SHALL be a synchronous clear of the count and the prescaler.
REQ-008 blank_lz  input  1  SHALL be 1 to blank leading zeros.
REQ-009 digito  output  4  SHALL be the BCD digit of the active slot, for the downstream 7-segment decoder.
REQ-010 anodos  output  4  SHALL be the active-low slot select; bit k drives digit k, where k=0 is units.
REQ-011 ciclo  output  1  SHALL be a one-cycle pulse when the count wraps.

Function
REQ-012 The count SHALL be four BCD digits d3..d0 (range 0000-9999); no digit SHALL ever hold a value above 9.
REQ-013 The prescaler pres SHALL count 0..TICK_DIV-1 while en=1, and SHALL wrap to 0 with tick=1 in the cycle where pres=TICK_DIV-1.
REQ-014 With TICK_DIV=1, tick SHALL be 1 in every cycle where en=1.
REQ-015 On tick with dir=0, the count SHALL increment by 1 in BCD with per-digit carry; from 9999 it SHALL go to 0000 with ciclo=1 in the next cycle.
REQ-016 On tick with dir=1, the count SHALL decrement by 1 in BCD with per-digit borrow; from 0000 it SHALL go to 9999 with ciclo=1 in the next cycle.
REQ-017 ciclo SHALL be registered, high for exactly one cycle per wrap, and low otherwise.
REQ-018 clr=1 SHALL force the count to 0000 and pres to 0 at the next edge; clr has priority over tick and en; ciclo SHALL be 0 in the cycle after a clear.
REQ-019 A change of dir SHALL take effect on the next tick; the count SHALL NOT jump.
REQ-020 The scan divider SHALL run continuously, independent of en and clr, counting 0..SCAN_DIV-1.
REQ-021 On each scan-divider wrap, the slot index sel SHALL advance 0->1->2->3->0.
REQ-022 digito and anodos SHALL be registered; the value after edge n SHALL reflect sel and the count as they were before edge n (1-cycle latency).
REQ-023 digito SHALL equal d[sel], and anodos SHALL equal ~(4'b0001 << sel).
REQ-024 Leading-zero blanking: when blank_lz=1, sel>0 and d[sel] plus every higher digit are all 0, anodos SHALL be 4'b1111 while digito still shows 0.
REQ-025 The units slot (sel=0) SHALL never be blanked, so 0000 displays a single 0.
REQ-026 At most one anodos bit SHALL be low in any cycle.

Reset
REQ-027 While rst_n=0, the block SHALL hold count=0000, pres=0, scan divider=0, sel=0, digito=4'h0, anodos=4'b1111 and ciclo=0, independent of clk.
REQ-028 Reset asserted mid-count or mid-scan SHALL clear the block immediately.
REQ-029 After rst_n is released, the first rising edge SHALL load anodos=4'b1110 and digito=0.

Verification
REQ-030 Up count: TICK_DIV=4, en=1, dir=0, starting from 0000 -> the count reads 0001 after 4 cycles and 0010 after 40 cycles, and digits never exceed 9.
REQ-031 Wrap both directions: preload 9999 via up-counting, then one tick -> 0000 with ciclo high for 1 cycle; with dir=1 at 0000, one tick -> 9999 with ciclo high for 1 cycle.
REQ-032 Scan: SCAN_DIV=2, count 4070, blank_lz=0 -> (anodos,digito) sequence 1110/0, 1101/7, 1011/0, 0111/4, with each slot held for 2 cycles.
REQ-033 Blanking: count 0050, blank_lz=1 -> slots 3 and 2 give anodos=1111, slot 1 gives 1101/5, slot 0 gives 1110/0; count 0000 -> only slot 0 is lit.
REQ-034 clr and en=0: clr asserted in the same cycle as a tick -> count 0000, ciclo=0; en=0 for 20 cycles -> count and pres unchanged while the scan continues.
REQ-035 Async reset: drop rst_n between clock edges at count 1234 -> all outputs reach their reset values with no clock edge.

Source files
------------

// File: rtl/secuencia_bcd_scan.sv
// Four-digit BCD up/down counter with prescaler and
// multiplexed, leading-zero-blanked display scan.
module secuencia_bcd_scan #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       clr,
    input  logic       blank_lz,
    output logic [3:0] digito,
    output logic [3:0] anodos,
    output logic       ciclo
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRES_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [PW-1:0]   pres_q, pres_d;
    logic [3:0][3:0] cnt_q, cnt_d;
    logic            ciclo_q, ciclo_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      digito_q, digito_d;
    logic [3:0]      anodos_q, anodos_d;
    logic            tick;
    logic            carry;
    logic [3:0]      lz;
    logic            blank;

    assign tick = en && (pres_q == PRES_MAX);

    // Prescaler and BCD count; a carry/borrow out of d3 is the wrap.
    always_comb begin
        pres_d  = pres_q;
        cnt_d   = cnt_q;
        ciclo_d = 1'b0;
        carry   = 1'b0;
        if (clr) begin
            pres_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            pres_d = tick ? '0 : pres_q + 1'b1;
            if (tick) begin
                carry = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (carry) begin
                        if (!dir) begin
                            if (cnt_q[k] == 4'd9) begin
                                cnt_d[k] = 4'd0;
                            end else begin
                                cnt_d[k] = cnt_q[k] + 4'd1;
                                carry    = 1'b0;
                            end
                        end else begin
                            if (cnt_q[k] == 4'd0) begin
                                cnt_d[k] = 4'd9;
                            end else begin
                                cnt_d[k] = cnt_q[k] - 4'd1;
                                carry    = 1'b0;
                            end
                        end
                    end
                end
                ciclo_d = carry;
            end
        end
    end

    // Free-running scan divider stepping the slot index.
    always_comb begin
        scan_d = scan_q + 1'b1;
        sel_d  = sel_q;
        if (scan_q == SCAN_MAX) begin
            scan_d = '0;
            sel_d  = sel_q + 2'd1;
        end
    end

    // lz[k] is set when digit k and all higher digits are zero.
    always_comb begin
        lz[3] = (cnt_q[3] == 4'd0);
        for (int k = 2; k >= 0; k--) begin
            lz[k] = lz[k+1] && (cnt_q[k] == 4'd0);
        end
    end

    // Display slot selection with leading-zero blanking.
    always_comb begin
        blank    = blank_lz && (sel_q != 2'd0) && lz[sel_q];
        digito_d = cnt_q[sel_q];
        anodos_d = blank ? 4'b1111 : ~(4'b0001 << sel_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_q   <= '0;
            cnt_q    <= '0;
            ciclo_q  <= 1'b0;
            scan_q   <= '0;
            sel_q    <= 2'd0;
            digito_q <= 4'h0;
            anodos_q <= 4'b1111;
        end else begin
            pres_q   <= pres_d;
            cnt_q    <= cnt_d;
            ciclo_q  <= ciclo_d;
            scan_q   <= scan_d;
            sel_q    <= sel_d;
            digito_q <= digito_d;
            anodos_q <= anodos_d;
        end
    end

    assign digito = digito_q;
    assign anodos = anodos_q;
    assign ciclo  = ciclo_q;

endmodule

// File: tb/tb_secuencia_bcd_scan.sv
// Directed bench for secuencia_bcd_scan: counts are read
// back through the display scan and checked against a queue.
module tb_secuencia_bcd_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       clr = 1'b0;
    logic       blank_lz = 1'b1;
    logic [3:0] digito;
    logic [3:0] anodos;
    logic       ciclo;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    logic [15:0] sb[$];
    logic [3:0]  an_s[17];
    logic [3:0]  dg_s[17];

    secuencia_bcd_scan #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir),
        .clr(clr), .blank_lz(blank_lz),
        .digito(digito), .anodos(anodos), .ciclo(ciclo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic en_cycles(input int n);
        en = 1'b1;
        repeat (n) @(negedge clk);
        en = 1'b0;
    endtask

    task automatic tick_run(input int k);
        en_cycles(4 * k);
        if (dir) cnt = (cnt + 10000 - k) % 10000;
        else     cnt = (cnt + k) % 10000;
        sb.push_back(to_bcd(cnt));
    endtask

    task automatic collect();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            an_s[i] = anodos;
            dg_s[i] = digito;
        end
    endtask

    function automatic int align();
        for (int i = 1; i <= 9; i++)
            if (an_s[i] == 4'b1110 && an_s[i-1] != 4'b1110) return i;
        return -1;
    endfunction

    function automatic logic [63:0] pack8(input int i);
        logic [63:0] r = '0;
        if (i < 0) return r;
        for (int j = 0; j < 8; j++) r = {r[55:0], an_s[i+j], dg_s[i+j]};
        return r;
    endfunction

    task automatic read_chk(input string tag);
        int i;
        logic [15:0] obs;
        logic [15:0] e;
        en = 1'b0;
        blank_lz = 1'b0;
        collect();
        i = align();
        obs = (i < 0) ? 16'hffff : {dg_s[i+6], dg_s[i+4], dg_s[i+2], dg_s[i]};
        e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        chk(tag, 64'(obs), 64'(e));
    endtask

    task automatic wrap_chk(input string tag);
        logic [4:0] c;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c[i] = ciclo;
        end
        en = 1'b0;
        @(negedge clk);
        c[4] = ciclo;
        chk(tag, 64'(c), 64'(5'b01000));
        if (dir) cnt = (cnt + 9999) % 10000;
        else     cnt = (cnt + 1) % 10000;
        sb.push_back(to_bcd(cnt));
    endtask

    initial begin
        int ne;
        logic nz;
        logic bad;

        repeat (2) @(negedge clk);
        chk("rst_digito", 64'(digito), 64'(4'h0));
        chk("rst_anodos", 64'(anodos), 64'(4'b1111));
        chk("rst_ciclo", 64'(ciclo), 64'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_edge", 64'({anodos, digito}), 64'(8'hE0));

        blank_lz = 1'b1;
        collect();
        ne = 0; nz = 1'b0; bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (an_s[i] == 4'b1110) ne++;
            else if (an_s[i] != 4'b1111) bad = 1'b1;
            if (dg_s[i] != 4'h0) nz = 1'b1;
        end
        chk("blank0000_lit", 64'(ne), 64'(4));
        chk("blank0000_other", 64'({bad, nz}), 64'(2'b00));

        en_cycles(4);
        cnt = 1;
        sb.push_back(to_bcd(cnt));
        read_chk("up_4cyc");
        en_cycles(36);
        cnt = 10;
        sb.push_back(to_bcd(cnt));
        read_chk("up_40cyc");

        tick_run(40);
        blank_lz = 1'b1;
        collect();
        chk("blank0050", pack8(align()), 64'hE0E0D5D5F0F0F0F0);
        read_chk("cnt0050");

        tick_run(4020);
        read_chk("cnt4070");
        chk("scan4070", pack8(align()), 64'hE0E0D7D7B0B07474);

        tick_run(5929);
        read_chk("cnt9999");
        wrap_chk("wrap_up_ciclo");
        read_chk("wrap_up_cnt");

        dir = 1'b1;
        wrap_chk("wrap_dn_ciclo");
        read_chk("wrap_dn_cnt");

        tick_run(3);
        read_chk("dn_9996");
        dir = 1'b0;
        tick_run(1);
        read_chk("dirchg_9997");

        tick_run(2);
        read_chk("pre_clr_9999");
        en_cycles(3);
        en = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        en = 1'b0;
        chk("clr_tick_ciclo", 64'(ciclo), 64'(1'b0));
        cnt = 0;
        sb.push_back(to_bcd(cnt));
        read_chk("clr_tick_cnt");

        en_cycles(2);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        en_cycles(3);
        sb.push_back(to_bcd(cnt));
        read_chk("clr_pres_3cyc");
        en_cycles(1);
        cnt = 1;
        sb.push_back(to_bcd(cnt));
        read_chk("clr_pres_4cyc");

        en_cycles(2);
        repeat (20) @(negedge clk);
        sb.push_back(to_bcd(cnt));
        read_chk("en0_hold");
        en_cycles(2);
        cnt = 2;
        sb.push_back(to_bcd(cnt));
        read_chk("en0_pres_held");

        tick_run(1232);
        read_chk("cnt1234");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 64'({digito, anodos, ciclo}), 64'({4'h0, 4'hF, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_edge", 64'({anodos, digito}), 64'(8'hE0));
        cnt = 0;
        sb.push_back(to_bcd(cnt));
        read_chk("post_rst_cnt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
